// File: rtl/posit_field_multiplier.sv
// rtl/posit_field_multiplier.sv - multi-cycle shift-add posit field multiplier
// Optional sticky output enabled by defining POSIT_MUL_STICKY_EN.
module posit_field_multiplier #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 ASign,
  input  logic                 BSign,
  input  logic [RS+1:0]        ARegime,
  input  logic [RS+1:0]        BRegime,
  input  logic [ES-1:0]        AExp,
  input  logic [ES-1:0]        BExp,
  input  logic [N-ES+2:0]      AMant,
  input  logic [N-ES+2:0]      BMant,
  input  logic                 AZero,
  input  logic                 BZero,
  input  logic                 ANaR,
  input  logic                 BNaR,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 OutSign,
  output logic [RS+ES+2:0]     OutScale,
  output logic [N-ES+2:0]      OutMant,
  output logic                 OutZero,
  output logic                 OutNaR,
  output logic                 OutSticky
);

  localparam int MW = N - ES + 3;
  localparam int SW = RS + ES + 3;
  localparam int CW = $clog2(MW);
  localparam logic [CW-1:0] LAST_ITER = CW'(MW - 1);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic [2*MW-1:0] p_q, p_d;
  logic [2*MW-1:0] mcand_q, mcand_d;
  logic [MW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   scale_q, scale_d;
  logic            out_sign_q, out_sign_d;
  logic [SW-1:0]   out_scale_q, out_scale_d;
  logic [MW-1:0]   out_mant_q, out_mant_d;
  logic            out_zero_q, out_zero_d;
  logic            out_nar_q, out_nar_d;

  logic [SW-1:0]   a_reg_ext, b_reg_ext, scale_sum;
  logic            any_nar, any_zero;

  // Regimes are signed; exponents are unsigned fraction-of-regime fields.
  assign a_reg_ext = {{(SW-RS-2){ARegime[RS+1]}}, ARegime};
  assign b_reg_ext = {{(SW-RS-2){BRegime[RS+1]}}, BRegime};
  assign scale_sum = (a_reg_ext << ES) + {{(SW-ES){1'b0}}, AExp}
                   + (b_reg_ext << ES) + {{(SW-ES){1'b0}}, BExp};
  assign any_nar   = ANaR | BNaR;
  assign any_zero  = AZero | BZero;

`ifdef POSIT_MUL_STICKY_EN
  logic out_sticky_q, out_sticky_d;
`endif

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    scale_d     = scale_q;
    out_sign_d  = out_sign_q;
    out_scale_d = out_scale_q;
    out_mant_d  = out_mant_q;
    out_zero_d  = out_zero_q;
    out_nar_d   = out_nar_q;
`ifdef POSIT_MUL_STICKY_EN
    out_sticky_d = out_sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (InValid) begin
          mcand_d     = {{MW{1'b0}}, AMant};
          mplier_d    = BMant;
          p_d         = '0;
          cnt_d       = '0;
          scale_d     = scale_sum;
          out_sign_d  = any_nar ? 1'b0 : (ASign ^ BSign);
          out_scale_d = '0;
          out_mant_d  = '0;
          out_nar_d   = any_nar;
          out_zero_d  = ~any_nar & any_zero;
`ifdef POSIT_MUL_STICKY_EN
          out_sticky_d = 1'b0;
`endif
          state_d     = (any_nar | any_zero) ? DONE : MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          p_d = p_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = NORM;
        end
      end
      NORM: begin
        // Product of two [1,2) mantissas lies in [1,4): at most one bit of renormalisation.
        if (p_q[2*MW-1]) begin
          out_mant_d  = p_q[2*MW-1:MW];
          out_scale_d = scale_q + SW'(1);
`ifdef POSIT_MUL_STICKY_EN
          out_sticky_d = |p_q[MW-1:0];
`endif
        end else begin
          out_mant_d  = p_q[2*MW-2:MW-1];
          out_scale_d = scale_q;
`ifdef POSIT_MUL_STICKY_EN
          out_sticky_d = |p_q[MW-2:0];
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q     <= IDLE;
      p_q         <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      scale_q     <= '0;
      out_sign_q  <= 1'b0;
      out_scale_q <= '0;
      out_mant_q  <= '0;
      out_zero_q  <= 1'b0;
      out_nar_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      scale_q     <= scale_d;
      out_sign_q  <= out_sign_d;
      out_scale_q <= out_scale_d;
      out_mant_q  <= out_mant_d;
      out_zero_q  <= out_zero_d;
      out_nar_q   <= out_nar_d;
    end
  end

`ifdef POSIT_MUL_STICKY_EN
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      out_sticky_q <= 1'b0;
    end else begin
      out_sticky_q <= out_sticky_d;
    end
  end
  assign OutSticky = out_sticky_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^p_q[MW-2:0];
  assign OutSticky = 1'b0;
`endif

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign OutSign  = out_sign_q;
  assign OutScale = out_scale_q;
  assign OutMant  = out_mant_q;
  assign OutZero  = out_zero_q;
  assign OutNaR   = out_nar_q;

endmodule

// File: tb/tb_posit_field_multiplier.sv
// tb/tb_posit_field_multiplier.sv - self-checking bench for posit_field_multiplier
module tb_posit_field_multiplier;

  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int MW = 8;
  localparam int SW = 9;
`ifdef POSIT_MUL_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic InValid = 1'b0;
  logic OutReady = 1'b0;
  logic InReady, OutValid;
  logic ASign = 1'b0, BSign = 1'b0;
  logic [RS+1:0] ARegime = '0, BRegime = '0;
  logic [ES-1:0] AExp = '0, BExp = '0;
  logic [MW-1:0] AMant = '0, BMant = '0;
  logic AZero = 1'b0, BZero = 1'b0, ANaR = 1'b0, BNaR = 1'b0;
  logic OutSign, OutZero, OutNaR, OutSticky;
  logic [SW-1:0] OutScale;
  logic [MW-1:0] OutMant;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  posit_field_multiplier #(.N(N), .ES(ES), .RS(RS)) dut (
    .Clk(Clk), .nReset(nReset), .InValid(InValid), .InReady(InReady),
    .ASign(ASign), .BSign(BSign), .ARegime(ARegime), .BRegime(BRegime),
    .AExp(AExp), .BExp(BExp), .AMant(AMant), .BMant(BMant),
    .AZero(AZero), .BZero(BZero), .ANaR(ANaR), .BNaR(BNaR),
    .OutValid(OutValid), .OutReady(OutReady), .OutSign(OutSign),
    .OutScale(OutScale), .OutMant(OutMant), .OutZero(OutZero),
    .OutNaR(OutNaR), .OutSticky(OutSticky)
  );

  typedef struct {
    bit as, bs;
    int areg, aexp, am;
    int breg, bexp, bm;
    bit az, bz, an, bn;
  } op_t;

  typedef struct {
    bit sign;
    int scale;
    int mant;
    bit zero, nar, sticky;
  } res_t;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: real product of the mantissas, scale from plain integer arithmetic.
  function automatic res_t model(input op_t o);
    res_t r;
    longint p;
    int sc;
    bit stk;
    r.sign = 1'b0; r.scale = 0; r.mant = 0; r.zero = 1'b0; r.nar = 1'b0; r.sticky = 1'b0;
    if (o.an || o.bn) begin
      r.nar = 1'b1;
    end else if (o.az || o.bz) begin
      r.zero = 1'b1;
      r.sign = o.as ^ o.bs;
    end else begin
      r.sign = o.as ^ o.bs;
      p  = longint'(o.am) * longint'(o.bm);
      sc = o.areg * (2 ** ES) + o.aexp + o.breg * (2 ** ES) + o.bexp;
      if (p >= (longint'(1) << (2 * MW - 1))) begin
        r.mant  = int'(p / (longint'(1) << MW));
        r.scale = sc + 1;
        stk     = (p % (longint'(1) << MW)) != 0;
      end else begin
        r.mant  = int'(p / (longint'(1) << (MW - 1)));
        r.scale = sc;
        stk     = (p % (longint'(1) << (MW - 1))) != 0;
      end
      r.sticky = STICKY_EN && stk;
    end
    return r;
  endfunction

  function automatic op_t mk_op(input int am, input int areg, input int aexp,
                                input int bm, input int breg, input int bexp);
    op_t o;
    o.as = 1'b0; o.bs = 1'b0;
    o.am = am; o.areg = areg; o.aexp = aexp;
    o.bm = bm; o.breg = breg; o.bexp = bexp;
    o.az = 1'b0; o.bz = 1'b0; o.an = 1'b0; o.bn = 1'b0;
    return o;
  endfunction

  function automatic op_t rand_op(input bit allow_special);
    op_t o;
    o.as   = 1'($urandom_range(0, 1));
    o.bs   = 1'($urandom_range(0, 1));
    o.am   = (1 << (MW - 1)) + int'($urandom_range(0, (1 << (MW - 1)) - 1));
    o.bm   = (1 << (MW - 1)) + int'($urandom_range(0, (1 << (MW - 1)) - 1));
    o.areg = int'($urandom_range(0, 31)) - 16;
    o.breg = int'($urandom_range(0, 31)) - 16;
    o.aexp = int'($urandom_range(0, 7));
    o.bexp = int'($urandom_range(0, 7));
    o.az = 1'b0; o.bz = 1'b0; o.an = 1'b0; o.bn = 1'b0;
    if (allow_special) begin
      o.az = ($urandom_range(0, 7) == 0);
      o.bz = ($urandom_range(0, 7) == 0);
      o.an = ($urandom_range(0, 9) == 0);
      o.bn = ($urandom_range(0, 9) == 0);
    end
    return o;
  endfunction

  task automatic drive(input op_t o);
    ASign = o.as; BSign = o.bs;
    ARegime = o.areg[RS+1:0]; BRegime = o.breg[RS+1:0];
    AExp = o.aexp[ES-1:0]; BExp = o.bexp[ES-1:0];
    AMant = o.am[MW-1:0]; BMant = o.bm[MW-1:0];
    AZero = o.az; BZero = o.bz; ANaR = o.an; BNaR = o.bn;
  endtask

  task automatic check_outputs(input string tag, input res_t r);
    check({tag, "_sign"},   OutSign,           r.sign);
    check({tag, "_scale"},  $signed(OutScale), r.scale);
    check({tag, "_mant"},   OutMant,           r.mant);
    check({tag, "_zero"},   OutZero,           r.zero);
    check({tag, "_nar"},    OutNaR,            r.nar);
    check({tag, "_sticky"}, OutSticky,         r.sticky);
  endtask

  // Accept one operand pair, measure latency, optionally stall, then retire it.
  task automatic run_op(input string tag, input op_t o, input int hold);
    res_t r;
    int lat;
    int exp_lat;
    r = model(o);
    exp_lat = (o.an || o.bn || o.az || o.bz) ? 0 : MW + 1;
    @(negedge Clk);
    check({tag, "_inready"}, InReady, 1);
    drive(o);
    InValid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    lat = 0;
    while (OutValid !== 1'b1 && lat < 40) begin
      @(posedge Clk);
      @(negedge Clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check_outputs(tag, r);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_hold_valid"}, OutValid, 1);
      check({tag, "_hold_inready"}, InReady, 0);
      check_outputs({tag, "_hold"}, r);
    end
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    OutReady = 1'b0;
    check({tag, "_retired_valid"}, OutValid, 0);
    check({tag, "_retired_inready"}, InReady, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o, o1, o2, o3;
    res_t m1, m2;
    int acc, ret;
    bit rdy, vld;

    // Reset state
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    check("rst_sign", OutSign, 0);
    check("rst_scale", OutScale, 0);
    check("rst_mant", OutMant, 0);
    check("rst_zero", OutZero, 0);
    check("rst_nar", OutNaR, 0);
    check("rst_sticky", OutSticky, 0);

    // Directed vectors
    run_op("unit", mk_op(8'h80, 0, 1, 8'h80, -1, 2), 0);
    run_op("carry", mk_op(8'hC0, 0, 0, 8'hC0, 0, 0), 0);
    run_op("sticky", mk_op(8'hC1, 0, 0, 8'h81, 0, 0), 0);
    o = mk_op(8'h80, 0, 0, 8'h80, 0, 0);
    o.an = 1'b1; o.bz = 1'b1; o.as = 1'b1;
    run_op("nar_zero", o, 5);
    o = mk_op(8'hA5, 3, 2, 8'hF0, -2, 5);
    o.az = 1'b1; o.as = 1'b1;
    run_op("zero", o, 2);
    run_op("max_scale", mk_op(8'hFF, 15, 7, 8'hFF, 15, 7), 0);
    run_op("min_scale", mk_op(8'h80, -16, 0, 8'h80, -16, 0), 0);

    // Reset in the middle of MUL
    @(negedge Clk);
    drive(mk_op(8'hE3, 1, 1, 8'h9A, 1, 1));
    InValid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    nReset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("midrst_inready", InReady, 1);
    check("midrst_outvalid", OutValid, 0);
    check("midrst_mant", OutMant, 0);
    nReset = 1'b1;
    run_op("after_rst", mk_op(8'hB7, -3, 4, 8'hD2, 2, 6), 0);

    // Back-to-back with InValid held high
    o1 = rand_op(1'b0);
    o2 = rand_op(1'b0);
    o3 = rand_op(1'b0);
    m1 = model(o1);
    m2 = model(o2);
    acc = 0;
    ret = 0;
    @(negedge Clk);
    drive(o1);
    InValid = 1'b1;
    OutReady = 1'b1;
    for (int c = 0; c < 2 * (MW + 3); c++) begin
      rdy = InReady;
      vld = OutValid;
      if (vld) begin
        check_outputs(ret == 0 ? "b2b_first" : "b2b_second", ret == 0 ? m1 : m2);
        ret++;
      end
      @(posedge Clk);
      @(negedge Clk);
      if (rdy) begin
        acc++;
        drive(acc == 1 ? o2 : o3);
      end
    end
    InValid = 1'b0;
    OutReady = 1'b0;
    check("b2b_accepts", acc, 2);
    check("b2b_retires", ret, 2);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), rand_op(1'b1), i % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
